// File: rtl/cond_select_arbiter.sv
// Registered model of priority/unique/unique0 if-else selection plus a round-robin mode,
// with one-cycle violation pulses, saturating violation counters and a sticky error flag.
`timescale 1ns/1ps

module cond_select_arbiter #(
  parameter int N     = 8,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     cond,
  input  logic             has_default,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             default_hit,
  output logic             overlap_err,
  output logic             nomatch_err,
  output logic [CNT_W-1:0] overlap_cnt,
  output logic [CNT_W-1:0] nomatch_cnt,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    MODE_PRIORITY = 2'b00,
    MODE_UNIQUE   = 2'b01,
    MODE_UNIQUE0  = 2'b10,
    MODE_RR       = 2'b11
  } mode_e;

  // Returns {hit, index} of the lowest set bit of v.
  function automatic logic [IDX_W:0] lowest_set(input logic [N-1:0] v);
    logic             hit;
    logic [IDX_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    return {hit, idx};
  endfunction

  mode_e              w_mode;
  logic               w_cond_zero;
  logic               w_multi_hit;
  logic               w_low_hit;
  logic [IDX_W-1:0]   w_low_idx;
  logic [2*N-1:0]     w_cond_dbl;
  logic [N-1:0]       w_cond_rot;
  logic               w_rot_hit;
  logic [IDX_W-1:0]   w_rot_off;
  logic [IDX_W:0]     w_rr_sum;
  logic [IDX_W-1:0]   w_rr_idx;
  logic [IDX_W:0]     w_ptr_inc;
  logic [IDX_W-1:0]   w_ptr_next;
  logic               w_sel_hit;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [N-1:0]       w_grant;
  logic               w_default;
  logic               w_overlap;
  logic               w_nomatch;
  logic               w_ovl_pulse;
  logic               w_nom_pulse;

  logic               r_out_valid;
  logic [N-1:0]       r_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic               r_default_hit;
  logic               r_overlap_err;
  logic               r_nomatch_err;
  logic [CNT_W-1:0]   r_overlap_cnt;
  logic [CNT_W-1:0]   r_nomatch_cnt;
  logic               r_err_sticky;
  logic [IDX_W-1:0]   r_rr_ptr;

  assign w_mode      = mode_e'(mode);
  assign w_cond_zero = (cond == '0);
  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  assign w_multi_hit = |(cond & (cond - 1'b1));

  assign {w_low_hit, w_low_idx} = lowest_set(cond);

  // Rotate cond so that bit rr_ptr lands at position 0, then take the lowest hit.
  assign w_cond_dbl = {cond, cond} >> r_rr_ptr;
  assign w_cond_rot = w_cond_dbl[N-1:0];
  assign {w_rot_hit, w_rot_off} = lowest_set(w_cond_rot);

  assign w_rr_sum = {1'b0, r_rr_ptr} + {1'b0, w_rot_off};
  assign w_rr_idx = (w_rr_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_rr_sum - (IDX_W+1)'(N))
                                                 : w_rr_sum[IDX_W-1:0];

  assign w_ptr_inc  = {1'b0, w_rr_idx} + 1'b1;
  assign w_ptr_next = (w_ptr_inc == (IDX_W+1)'(N)) ? '0 : w_ptr_inc[IDX_W-1:0];

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sel_hit = w_low_hit;
    w_sel_idx = w_low_idx;
    w_overlap = 1'b0;
    w_nomatch = 1'b0;
    w_default = w_cond_zero && has_default;
    unique case (w_mode)
      MODE_PRIORITY: begin
        w_nomatch = w_cond_zero && !has_default;
      end
      MODE_UNIQUE: begin
        w_overlap = w_multi_hit;
        w_nomatch = w_cond_zero && !has_default;
      end
      MODE_UNIQUE0: begin
        w_overlap = w_multi_hit;
      end
      MODE_RR: begin
        w_sel_hit = w_rot_hit;
        w_sel_idx = w_rr_idx;
      end
    endcase
  end

  assign w_grant     = w_sel_hit ? (N'(1) << w_sel_idx) : '0;
  assign w_ovl_pulse = in_valid && w_overlap;
  assign w_nom_pulse = in_valid && w_nomatch;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_default_hit <= 1'b0;
      r_overlap_err <= 1'b0;
      r_nomatch_err <= 1'b0;
      r_rr_ptr      <= '0;
    end else begin
      r_out_valid   <= in_valid;
      r_grant       <= in_valid ? w_grant : '0;
      r_grant_idx   <= (in_valid && w_sel_hit) ? w_sel_idx : '0;
      r_default_hit <= in_valid && w_default;
      r_overlap_err <= w_ovl_pulse;
      r_nomatch_err <= w_nom_pulse;
      if (in_valid && (w_mode == MODE_RR) && w_rot_hit) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  // A clear issued alongside an error wins; the pulse itself is still reported above.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_overlap_cnt <= '0;
      r_nomatch_cnt <= '0;
      r_err_sticky  <= 1'b0;
    end else begin
      if (w_ovl_pulse && (r_overlap_cnt != '1)) begin
        r_overlap_cnt <= r_overlap_cnt + 1'b1;
      end
      if (w_nom_pulse && (r_nomatch_cnt != '1)) begin
        r_nomatch_cnt <= r_nomatch_cnt + 1'b1;
      end
      if (w_ovl_pulse || w_nom_pulse) begin
        r_err_sticky <= 1'b1;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign default_hit = r_default_hit;
  assign overlap_err = r_overlap_err;
  assign nomatch_err = r_nomatch_err;
  assign overlap_cnt = r_overlap_cnt;
  assign nomatch_cnt = r_nomatch_cnt;
  assign err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_cond_select_arbiter.sv
// Scoreboard bench for cond_select_arbiter: two instances (CNT_W 16 and 2) share stimulus,
// a behavioural model queues expected outputs, and a negedge monitor compares them.
`timescale 1ns/1ps

module tb_cond_select_arbiter;

  localparam logic [1:0] M_PRI = 2'b00;
  localparam logic [1:0] M_UNQ = 2'b01;
  localparam logic [1:0] M_UQ0 = 2'b10;
  localparam logic [1:0] M_RR  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] cond = '0;
  logic       has_default = 1'b0;
  logic       clr_cnt = 1'b0;

  logic        ov_a, dh_a, oe_a, ne_a, st_a;
  logic [7:0]  gr_a;
  logic [2:0]  gi_a;
  logic [15:0] oc_a, nc_a;
  logic        ov_b, dh_b, oe_b, ne_b, st_b;
  logic [7:0]  gr_b;
  logic [2:0]  gi_b;
  logic [1:0]  oc_b, nc_b;

  always #5 clk = ~clk;

  cond_select_arbiter #(.N(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .cond(cond),
    .has_default(has_default), .clr_cnt(clr_cnt), .out_valid(ov_a), .grant(gr_a),
    .grant_idx(gi_a), .default_hit(dh_a), .overlap_err(oe_a), .nomatch_err(ne_a),
    .overlap_cnt(oc_a), .nomatch_cnt(nc_a), .err_sticky(st_a)
  );

  cond_select_arbiter #(.N(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .cond(cond),
    .has_default(has_default), .clr_cnt(clr_cnt), .out_valid(ov_b), .grant(gr_b),
    .grant_idx(gi_b), .default_hit(dh_b), .overlap_err(oe_b), .nomatch_err(ne_b),
    .overlap_cnt(oc_b), .nomatch_cnt(nc_b), .err_sticky(st_b)
  );

  typedef struct {
    logic       ov;
    logic [7:0] gr;
    logic [2:0] gi;
    logic       dh;
    logic       oe;
    logic       ne;
    int         oc_a;
    int         nc_a;
    int         oc_b;
    int         nc_b;
    logic       st;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Model state
  int   m_ptr = 0;
  int   m_oc_a = 0, m_nc_a = 0, m_oc_b = 0, m_nc_b = 0;
  logic m_st = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  function automatic exp_t model_step(input logic r, input logic v, input logic [1:0] md,
                                      input logic [7:0] c, input logic hd, input logic clr);
    exp_t e;
    int   idx;
    int   ones;
    e = '{ov: 1'b0, gr: 8'h00, gi: 3'd0, dh: 1'b0, oe: 1'b0, ne: 1'b0,
          oc_a: 0, nc_a: 0, oc_b: 0, nc_b: 0, st: 1'b0};
    if (r) begin
      m_ptr = 0; m_oc_a = 0; m_nc_a = 0; m_oc_b = 0; m_nc_b = 0; m_st = 1'b0;
      return e;
    end
    if (v) begin
      e.ov = 1'b1;
      idx  = -1;
      ones = $countones(c);
      if (md == M_RR) begin
        for (int k = 0; k < 8; k++) begin
          if (idx < 0 && c[(m_ptr + k) % 8]) idx = (m_ptr + k) % 8;
        end
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (idx < 0 && c[k]) idx = k;
        end
      end
      if (idx >= 0) begin
        e.gr = 8'(1 << idx);
        e.gi = 3'(idx);
        if (md == M_RR) m_ptr = (idx + 1) % 8;
      end
      e.dh = (c == 8'h00) && hd;
      e.oe = (md == M_UNQ || md == M_UQ0) && (ones > 1);
      e.ne = (md == M_PRI || md == M_UNQ) && (c == 8'h00) && !hd;
    end
    if (clr) begin
      m_oc_a = 0; m_nc_a = 0; m_oc_b = 0; m_nc_b = 0; m_st = 1'b0;
    end else begin
      if (e.oe) begin m_oc_a = sat_inc(m_oc_a, 65535); m_oc_b = sat_inc(m_oc_b, 3); end
      if (e.ne) begin m_nc_a = sat_inc(m_nc_a, 65535); m_nc_b = sat_inc(m_nc_b, 3); end
      if (e.oe || e.ne) m_st = 1'b1;
    end
    e.oc_a = m_oc_a; e.nc_a = m_nc_a; e.oc_b = m_oc_b; e.nc_b = m_nc_b; e.st = m_st;
    return e;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [1:0] md,
                       input logic [7:0] c, input logic hd, input logic clr);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; mode = md; cond = c; has_default = hd; clr_cnt = clr;
    e = model_step(r, v, md, c, hd, clr);
    @(posedge clk);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      check("out_valid_a",   64'(ov_a), 64'(m_e.ov));
      check("grant_a",       64'(gr_a), 64'(m_e.gr));
      check("grant_idx_a",   64'(gi_a), 64'(m_e.gi));
      check("default_hit_a", 64'(dh_a), 64'(m_e.dh));
      check("overlap_err_a", 64'(oe_a), 64'(m_e.oe));
      check("nomatch_err_a", 64'(ne_a), 64'(m_e.ne));
      check("overlap_cnt_a", 64'(oc_a), 64'(m_e.oc_a));
      check("nomatch_cnt_a", 64'(nc_a), 64'(m_e.nc_a));
      check("err_sticky_a",  64'(st_a), 64'(m_e.st));
      check("grant_b",       64'(gr_b), 64'(m_e.gr));
      check("grant_idx_b",   64'(gi_b), 64'(m_e.gi));
      check("overlap_err_b", 64'(oe_b), 64'(m_e.oe));
      check("nomatch_err_b", 64'(ne_b), 64'(m_e.ne));
      check("overlap_cnt_b", 64'(oc_b), 64'(m_e.oc_b));
      check("nomatch_cnt_b", 64'(nc_b), 64'(m_e.nc_b));
      check("err_sticky_b",  64'(st_b), 64'(m_e.st));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] rc;
    // Reset
    drive(1, 0, M_PRI, 8'h00, 0, 0);
    drive(1, 0, M_PRI, 8'h00, 0, 0);
    // PRIORITY: lowest bit, then nomatch
    drive(0, 1, M_PRI, 8'b0110_0100, 0, 0);
    drive(0, 1, M_PRI, 8'h00, 0, 0);
    // UNIQUE: overlap, then default
    drive(0, 1, M_UNQ, 8'b1000_0010, 0, 0);
    drive(0, 1, M_UNQ, 8'h00, 1, 0);
    drive(0, 1, M_UNQ, 8'b0001_0000, 0, 0);
    // UNIQUE0: silent no-match, then overlap
    drive(0, 1, M_UQ0, 8'h00, 0, 0);
    drive(0, 1, M_UQ0, 8'b0000_0011, 0, 0);
    drive(0, 0, M_UQ0, 8'hFF, 0, 0);
    // ROUND_ROBIN: ten full requests, then wrap-around to bit 0
    for (int i = 0; i < 10; i++) drive(0, 1, M_RR, 8'hFF, 0, 0);
    drive(0, 1, M_RR, 8'b0000_0001, 0, 0);
    drive(0, 1, M_RR, 8'h00, 1, 0);
    drive(0, 1, M_RR, 8'h00, 0, 0);
    // Mode switch leaves rr_ptr alone
    drive(0, 1, M_RR, 8'h08, 0, 0);
    drive(0, 1, M_PRI, 8'hFF, 0, 0);
    drive(0, 1, M_UNQ, 8'hFF, 0, 0);
    drive(0, 1, M_RR, 8'hFF, 0, 0);
    // Counter saturation on the 2-bit instance, clear racing an overlap
    drive(0, 0, M_PRI, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 1, M_UNQ, 8'b0000_0011, 0, 0);
    drive(0, 1, M_UNQ, 8'b0000_0011, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 1, M_PRI, 8'h00, 0, 0);
    drive(0, 0, M_PRI, 8'h00, 0, 1);
    drive(0, 0, M_PRI, 8'h00, 0, 0);
    // Reset mid-stream with rr_ptr = 5
    drive(0, 1, M_RR, 8'h10, 0, 0);
    drive(1, 1, M_RR, 8'hFF, 0, 0);
    drive(0, 1, M_RR, 8'hFF, 0, 0);
    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(3))
        0:       rc = 8'h00;
        1:       rc = 8'(1 << $urandom_range(7));
        default: rc = 8'($urandom);
      endcase
      drive(($urandom_range(39) == 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
            rc, 1'($urandom_range(1)), ($urandom_range(15) == 0));
    end
    drive(0, 0, M_PRI, 8'h00, 0, 0);
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
